// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and helpers for the read and write controllers.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int FIFO_PTR_W = 3;              // storage address width
  localparam int FIFO_CNT_W = FIFO_PTR_W + 2; // occupancy count, 0..2*depth

  // Pointers carry one extra wrap bit above the storage address.
  typedef logic [FIFO_PTR_W:0]   fifo_ptr_t;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

  // Read-side output register state: HOLD means rd_valid is asserted.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_e;

  // Full when the wrap bits differ and the address bits match.
  function automatic logic ptr_full(input fifo_ptr_t w_ptr, input fifo_ptr_t r_ptr);
    return (w_ptr[FIFO_PTR_W] != r_ptr[FIFO_PTR_W]) &&
           (w_ptr[FIFO_PTR_W-1:0] == r_ptr[FIFO_PTR_W-1:0]);
  endfunction

  // Empty when both pointers, wrap bit included, are identical.
  function automatic logic ptr_empty(input fifo_ptr_t w_ptr, input fifo_ptr_t r_ptr);
    return w_ptr == r_ptr;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: pulls entries from fifo_storage into a one-entry output register.
// Latency: w_ptr advance at edge E -> r_en in the following cycle -> rd_valid after the next edge.
// Backpressure: rd_valid/rd_data hold while rd_ready=0; refill same edge as accept (1 entry/cycle).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = FIFO_PTR_W,
  parameter int FIFO_DEPTH = 2 ** PTR_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic [PTR_WIDTH:0]    w_ptr,
  input  logic                  flush,
  output logic                  r_en,
  output logic [PTR_WIDTH-1:0]  r_addr,
  input  logic [DATA_WIDTH-1:0] st_rd_data,
  output logic [PTR_WIDTH:0]    r_ptr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [PTR_WIDTH+1:0]  level,
  output logic                  ptr_err
);

  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] PTR_ONE   = (PTR_WIDTH + 1)'(1);

  rd_state_e                 state_q;
  rd_state_e                 state_d;
  logic [PTR_WIDTH:0]        st_cnt;
  logic                      st_empty;
  logic                      load;

  // Storage occupancy from the pointer difference; the wrap bit makes modulo math exact.
  always_comb begin
    st_cnt   = w_ptr - r_ptr;
    st_empty = (w_ptr == r_ptr);
    rd_valid = (state_q == RD_HOLD);
    load     = !st_empty && (!rd_valid || rd_ready) && !flush;
    r_en     = load;
    r_addr   = r_ptr[PTR_WIDTH-1:0];
    empty    = st_empty && !rd_valid;
    level    = {1'b0, st_cnt} + (PTR_WIDTH + 2)'(rd_valid);
  end

  // Output register state: flush empties it, a load fills it, an accept without refill drains it.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RD_IDLE;
    end else if (load) begin
      state_d = RD_HOLD;
    end else if (rd_valid && rd_ready) begin
      state_d = RD_IDLE;
    end
  end

  // State register.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read pointer and captured data: flush resyncs to the writer, a load consumes one entry.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_ptr   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      r_ptr   <= w_ptr;
    end else if (load) begin
      r_ptr   <= r_ptr + PTR_ONE;
      rd_data <= st_rd_data;
    end
  end

  // Sticky overrun flag: the writer got more than a full FIFO ahead of us.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      ptr_err <= 1'b0;
    end else if (flush) begin
      ptr_err <= 1'b0;
    end else if (st_cnt > DEPTH_CNT) begin
      ptr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl; the bench plays the write controller and storage.
// Latency: n/a.
// Backpressure: rd_ready driven by the stimulus.
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;

  logic          rd_clk = 1'b0;
  logic          rd_rstn = 1'b0;
  logic [PW:0]   w_ptr = '0;
  logic          flush = 1'b0;
  logic          r_en;
  logic [PW-1:0] r_addr;
  logic [DW-1:0] st_rd_data;
  logic [PW:0]   r_ptr;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [PW+1:0] level;
  logic          ptr_err;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] exp_q [$];
  logic          mon_en = 1'b0;
  logic          saw_78 = 1'b0;
  logic          saw_f0 = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_pop = 0;
  int            ren_cnt;
  int            pushed;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .FIFO_DEPTH(8)) dut (
    .rd_clk    (rd_clk),
    .rd_rstn   (rd_rstn),
    .w_ptr     (w_ptr),
    .flush     (flush),
    .r_en      (r_en),
    .r_addr    (r_addr),
    .st_rd_data(st_rd_data),
    .r_ptr     (r_ptr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .empty     (empty),
    .level     (level),
    .ptr_err   (ptr_err)
  );

  always #5 rd_clk = ~rd_clk;

  assign st_rd_data = mem[r_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A write that landed at the last edge: storage updated, w_ptr advanced.
  task automatic push(input logic [DW-1:0] d);
    mem[w_ptr[PW-1:0]] = d;
    w_ptr = w_ptr + 1'b1;
    exp_q.push_back(d);
  endtask

  // Score a handshake just before the edge, then advance to 1 time unit after the edge.
  task automatic tick();
    logic [PW:0] prev;
    if (mon_en && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) check("stream_extra", 32'd1, 32'd0);
      else begin
        check("stream_data", 32'(rd_data), 32'(exp_q.pop_front()));
        n_pop++;
      end
    end
    prev = r_ptr;
    @(posedge rd_clk);
    #1;
    if (prev == 4'd7 && r_ptr == 4'd8) saw_78 = 1'b1;
    if (prev == 4'd15 && r_ptr == 4'd0) saw_f0 = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (3) @(posedge rd_clk);
    #1;
    check("rst_r_ptr", 32'(r_ptr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rd_rstn = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", 32'(rd_valid), 32'd0);
      check("idle_empty", 32'(empty), 32'd1);
      check("idle_level", 32'(level), 32'd0);
      check("idle_ren", 32'(r_en), 32'd0);
    end

    // Three writes, reader always ready: back-to-back delivery.
    rd_ready = 1'b1;
    push(8'h11);
    #1;
    check("w1_ren", 32'(r_en), 32'd1);
    check("w1_level", 32'(level), 32'd1);
    check("w1_valid_early", 32'(rd_valid), 32'd0);
    tick();
    check("w1_valid", 32'(rd_valid), 32'd1);
    check("w1_data", 32'(rd_data), 32'h11);
    push(8'h22);
    tick();
    check("w2_data", 32'(rd_data), 32'h22);
    push(8'h33);
    tick();
    check("w3_data", 32'(rd_data), 32'h33);
    check("w3_valid", 32'(rd_valid), 32'd1);
    tick();
    check("w3_drained", 32'(rd_valid), 32'd0);
    check("w3_empty", 32'(empty), 32'd1);
    check("w3_r_ptr", 32'(r_ptr), 32'd3);

    // Fill 8 with the reader stalled: only one read into the output register.
    exp_q.delete();
    rd_ready = 1'b0;
    ren_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      push(8'hA0 + 8'(i));
      #1;
      if (r_en) ren_cnt++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (r_en) ren_cnt++;
      tick();
    end
    check("fill_ren_once", 32'(ren_cnt), 32'd1);
    check("fill_valid", 32'(rd_valid), 32'd1);
    check("fill_data", 32'(rd_data), 32'hA0);
    check("fill_level", 32'(level), 32'd8);
    check("fill_empty", 32'(empty), 32'd0);

    // Drain with scoreboard.
    mon_en = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_r_ptr", 32'(r_ptr), 32'd11);

    // Stream 20 with toggling ready; pointer must wrap through 7->8 and 15->0.
    saw_78 = 1'b0;
    saw_f0 = 1'b0;
    n_pop = 0;
    pushed = 0;
    for (int cyc = 0; cyc < 300 && (pushed < 20 || exp_q.size() > 0); cyc++) begin
      rd_ready = (cyc % 2 == 0);
      if (pushed < 20 && 4'(w_ptr - r_ptr) < 4'd8) begin
        push(8'h40 + 8'(pushed));
        pushed++;
      end
      tick();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("stream_pops", 32'(n_pop), 32'd20);
    check("stream_left", 32'(exp_q.size()), 32'd0);
    check("stream_r_ptr", 32'(r_ptr), 32'd15);
    check("wrap_7_8", 32'(saw_78), 32'd1);
    check("wrap_15_0", 32'(saw_f0), 32'd1);
    check("stream_empty", 32'(empty), 32'd1);

    // Flush with level 5.
    mon_en = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(8'hC0 + 8'(i));
      tick();
    end
    tick();
    check("pre_flush_level", 32'(level), 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_valid", 32'(rd_valid), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ptr_eq", 32'(r_ptr), 32'(w_ptr));
    check("flush_level", 32'(level), 32'd0);
    check("flush_err", 32'(ptr_err), 32'd0);

    // Write landing at the flush edge is kept.
    flush = 1'b1;
    tick();
    push(8'h5A);
    flush = 1'b0;
    #1;
    check("flushw_ren", 32'(r_en), 32'd1);
    check("flushw_level", 32'(level), 32'd1);
    tick();
    check("flushw_valid", 32'(rd_valid), 32'd1);
    check("flushw_data", 32'(rd_data), 32'h5A);
    rd_ready = 1'b1;
    tick();
    check("flushw_done", 32'(rd_valid), 32'd0);
    exp_q.delete();

    // Overrun: writer jumps 9 ahead.
    rd_ready = 1'b0;
    w_ptr = w_ptr + 4'd9;
    #1;
    check("err_not_yet", 32'(ptr_err), 32'd0);
    tick();
    check("err_set", 32'(ptr_err), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("err_sticky", 32'(ptr_err), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("err_cleared", 32'(ptr_err), 32'd0);
    check("err_ptr_eq", 32'(r_ptr), 32'(w_ptr));

    // Async reset mid-burst.
    w_ptr = w_ptr + 4'd10;
    rd_ready = 1'b1;
    tick();
    tick();
    check("burst_valid", 32'(rd_valid), 32'd1);
    check("burst_err", 32'(ptr_err), 32'd1);
    #2;
    rd_rstn = 1'b0;
    w_ptr = '0;
    #1;
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_r_ptr", 32'(r_ptr), 32'd0);
    check("arst_err", 32'(ptr_err), 32'd0);
    check("arst_data", 32'(rd_data), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    tick();
    rd_rstn = 1'b1;
    tick();
    check("post_rst_valid", 32'(rd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
